// File: rtl/rotl_seq.sv
// Iterative rotate-left: the word is rotated up to STEP bits per clock until the
// requested run-time amount is consumed, then held in DONE until the consumer takes it.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// ROT   | rotating data_q by min(STEP, rem_q) each clock
// DONE  | result presented on out_data; waits for out_ready
module rotl_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // k never exceeds STEP, so only the low log2(STEP)+1 rotate stages are built.
  localparam int          SL     = $clog2(STEP);
  localparam int          NST    = (SL < AW) ? SL + 1 : AW;
  localparam logic [AW:0] STEP_C = (AW + 1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [AW-1:0]    k;
  logic [WIDTH-1:0] stage [NST+1];

  // With STEP == WIDTH the first branch is unreachable since rem_q < WIDTH.
  always_comb begin
    k = ({1'b0, rem_q} >= STEP_C) ? STEP_C[AW-1:0] : rem_q;
  end

  assign stage[0] = data_q;

  for (genvar j = 0; j < NST; j++) begin : g_rot
    localparam int SH = 1 << j;
    assign stage[j+1] = k[j] ? {stage[j][WIDTH-1-SH:0], stage[j][WIDTH-1:WIDTH-SH]}
                             : stage[j];
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_amt;
          state_d = (in_amt == '0) ? S_DONE : S_ROT;
        end
      end
      S_ROT: begin
        data_d = stage[NST];
        rem_d  = rem_q - k;
        if (rem_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_rotl_seq.sv
// Bench for rotl_seq: a STEP=1 and a STEP=8 instance, directed cases then random
// operations compared against an arithmetic rotate and latency model.
module tb_rotl_seq;

  logic             clk;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][31:0] in_data;
  logic [1:0][4:0]  in_amt;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][31:0] out_data;
  logic [1:0]       busy;

  int n_pass  = 0;
  int n_total = 0;

  rotl_seq #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_amt(in_amt[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  rotl_seq #(.WIDTH(32), .STEP(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_amt(in_amt[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step_of(input int u);
    return (u == 0) ? 1 : 8;
  endfunction

  function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int a);
    logic [63:0] t;
    t = {x, x} << a;
    return t[63:32];
  endfunction

  function automatic int lat_ref(input int u, input int a);
    return 1 + (a + step_of(u) - 1) / step_of(u);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic start_op(input int u, input logic [31:0] d, input int a);
    @(negedge clk);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_amt[u]   = 5'(a);
    chk("in_ready_idle", 64'(in_ready[u]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    in_data[u]  = $urandom;
    in_amt[u]   = 5'($urandom);
  endtask

  task automatic wait_done(input int u, input logic [31:0] src, input int a, input string tag);
    int lat;
    lat = 1;
    if (a != 0) chk({tag, "_busy"}, 64'(busy[u]), 64'd1);
    while (!out_valid[u] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(lat_ref(u, a)));
    chk({tag, "_data"}, 64'(out_data[u]), 64'(rotl_ref(src, a)));
    chk({tag, "_pop"}, 64'($countones(out_data[u])), 64'($countones(src)));
  endtask

  task automatic retire(input int u, input logic [31:0] exp_d, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid[u]), 64'd1);
      chk("hold_data", 64'(out_data[u]), 64'(exp_d));
      chk("hold_in_ready", 64'(in_ready[u]), 64'd0);
    end
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    chk("retire_valid", 64'(out_valid[u]), 64'd0);
    chk("retire_in_ready", 64'(in_ready[u]), 64'd1);
    chk("retire_busy", 64'(busy[u]), 64'd0);
  endtask

  task automatic full_op(input int u, input logic [31:0] d, input int a, input int hold, input string tag);
    start_op(u, d, a);
    wait_done(u, d, a, tag);
    retire(u, rotl_ref(d, a), hold);
  endtask

  initial begin
    logic [31:0] d;
    int          a;
    int          u;

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = '0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 64'(in_ready[i]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_out_data", 64'(out_data[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    out_ready[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_ready_valid", 64'(out_valid[0]), 64'd0);
    chk("idle_out_ready_in_ready", 64'(in_ready[0]), 64'd1);
    out_ready[0] = 1'b0;

    full_op(0, 32'h8000_0001, 1, 0, "s1_amt1");
    full_op(0, 32'h1234_5678, 4, 1, "s1_amt4");
    full_op(0, 32'h8123_4567, 4, 0, "s1_roundtrip");
    full_op(0, 32'hDEAD_BEEF, 0, 2, "s1_amt0");
    full_op(1, 32'h0000_0001, 31, 0, "s8_amt31");
    full_op(1, 32'hDEAD_BEEF, 0, 0, "s8_amt0");
    full_op(1, 32'hF000_000F, 8, 1, "s8_amt8");

    // Backpressure with a pending request that must not be taken in DONE.
    start_op(0, 32'hA5A5_0F0F, 3);
    wait_done(0, 32'hA5A5_0F0F, 3, "bp");
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h0000_00FF;
    in_amt[0]   = 5'd8;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid[0]), 64'd1);
      chk("bp_data", 64'(out_data[0]), 64'(rotl_ref(32'hA5A5_0F0F, 3)));
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    chk("bp_retire_valid", 64'(out_valid[0]), 64'd0);
    chk("bp_retire_in_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_done(0, 32'h0000_00FF, 8, "bp_pending");
    retire(0, rotl_ref(32'h0000_00FF, 8), 0);

    // Reset during ROT cycle 7 of a 20-bit rotate.
    start_op(0, 32'h0F0F_1234, 20);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("mid_rst_out_data", 64'(out_data[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_op(0, 32'h0000_0001, 5, 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      u = int'($urandom_range(1, 0));
      d = $urandom;
      a = int'($urandom_range(31, 0));
      full_op(u, d, a, int'($urandom_range(3, 0)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
